// File: rtl/gpu_pkg.sv
// Shared types for the PPU write path: pixel/address widths and the per-core write record.
package gpu_pkg;

    localparam int unsigned COLOR_WIDTH   = 16;
    localparam int unsigned BUFFER_ADDR_W = 32;

    typedef logic [COLOR_WIDTH-1:0]   color_t;
    typedef logic [BUFFER_ADDR_W-1:0] addr_t;

    typedef struct packed {
        addr_t  addr;
        color_t data;
    } ppu_wr_t;

    // Index width that stays at least 1 bit for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ppu_wr_fifo.sv
// Synchronous FIFO of PPU write records; push while full and pop while empty are ignored.
module ppu_wr_fifo
    import gpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  ppu_wr_t wr,
    output ppu_wr_t head_c,
    output logic    full_c,
    output logic    empty_c,
    output logic    one_c
);

    localparam int unsigned PTR_W = idx_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    ppu_wr_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full_c  = (count == CNT_W'(DEPTH));
        empty_c = (count == '0);
        one_c   = (count == CNT_W'(1));
        do_push = push & ~full_c;
        do_pop  = pop & ~empty_c;
        head_c  = mem[rd_ptr];
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr;
    end

endmodule

// File: rtl/ppu_write_collector.sv
// Collects per-core PPU pixel writes into small FIFOs and merges them round-robin
// onto one Avalon-MM write master, with end-of-frame drain and overflow reporting.
module ppu_write_collector
    import gpu_pkg::*;
#(
    parameter int unsigned CORES_COUNT = 10,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned CORE_STRIDE = 96000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [COLOR_WIDTH-1:0]   ppu_data    [CORES_COUNT],
    input  logic [BUFFER_ADDR_W-1:0] ppu_address [CORES_COUNT],
    input  logic [CORES_COUNT-1:0]   ppu_valid,
    input  logic [BUFFER_ADDR_W-1:0] fb_base,
    input  logic                     frame_start,
    input  logic                     frame_end,
    output logic [BUFFER_ADDR_W-1:0] avm_address,
    output logic [COLOR_WIDTH-1:0]   avm_writedata,
    output logic                     avm_write,
    input  logic                     avm_waitrequest,
    output logic                     drained,
    output logic [CORES_COUNT-1:0]   overflow,
    output logic                     busy
);

    localparam int unsigned IDX_W = idx_width(CORES_COUNT);

    ppu_wr_t                    head_c [CORES_COUNT];
    logic [CORES_COUNT-1:0]     full_c;
    logic [CORES_COUNT-1:0]     empty_c;
    logic [CORES_COUNT-1:0]     one_c;
    logic [CORES_COUNT-1:0]     pop_c;
    logic [CORES_COUNT-1:0]     empty_nxt_c;

    logic [IDX_W-1:0]           rr_ptr;
    logic                       pending_end;

    int unsigned                idx_c;
    logic                       found_c;
    logic [IDX_W-1:0]           sel_c;
    logic                       load_c;
    logic                       pend_raw_c;

    logic [IDX_W-1:0]           rr_ptr_nxt;
    logic                       pending_end_nxt;
    logic [BUFFER_ADDR_W-1:0]   addr_nxt;
    logic [COLOR_WIDTH-1:0]     data_nxt;
    logic                       write_nxt;
    logic                       drained_nxt;
    logic [CORES_COUNT-1:0]     overflow_nxt;
    logic                       busy_nxt;

    for (genvar g = 0; g < CORES_COUNT; g++) begin : g_fifo
        ppu_wr_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .push    (ppu_valid[g]),
            .pop     (pop_c[g]),
            .wr      ({ppu_address[g], ppu_data[g]}),
            .head_c  (head_c[g]),
            .full_c  (full_c[g]),
            .empty_c (empty_c[g]),
            .one_c   (one_c[g])
        );
    end

    // Arbitration, issue-register load and end-of-frame bookkeeping.
    always_comb begin
        idx_c           = 0;
        found_c         = 1'b0;
        sel_c           = '0;
        pop_c           = '0;
        rr_ptr_nxt      = rr_ptr;
        addr_nxt        = avm_address;
        data_nxt        = avm_writedata;
        write_nxt       = avm_write;
        load_c          = ~avm_write | ~avm_waitrequest;

        for (int unsigned k = 0; k < CORES_COUNT; k++) begin
            idx_c = (32'(rr_ptr) + k) % CORES_COUNT;
            if (!found_c && !empty_c[IDX_W'(idx_c)]) begin
                found_c = 1'b1;
                sel_c   = IDX_W'(idx_c);
            end
        end

        if (load_c) begin
            write_nxt = found_c;
            if (found_c) begin
                pop_c[sel_c] = 1'b1;
                addr_nxt     = fb_base + BUFFER_ADDR_W'(64'(sel_c) * 64'(CORE_STRIDE))
                             + head_c[sel_c].addr;
                data_nxt     = head_c[sel_c].data;
                rr_ptr_nxt   = (sel_c == IDX_W'(CORES_COUNT - 1)) ? '0 : sel_c + IDX_W'(1);
            end
        end

        // Drops are judged against the occupancy before this cycle's pop.
        empty_nxt_c     = ~(ppu_valid & ~full_c) & (empty_c | (one_c & pop_c));
        overflow_nxt    = (frame_start ? '0 : overflow) | (ppu_valid & full_c);

        pend_raw_c      = frame_end | (pending_end & ~frame_start);
        drained_nxt     = pend_raw_c & (&empty_nxt_c) & ~write_nxt;
        pending_end_nxt = pend_raw_c & ~drained_nxt;
        busy_nxt        = ~(&empty_nxt_c) | write_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            pending_end   <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            avm_write     <= 1'b0;
            drained       <= 1'b0;
            overflow      <= '0;
            busy          <= 1'b0;
        end else begin
            rr_ptr        <= rr_ptr_nxt;
            pending_end   <= pending_end_nxt;
            avm_address   <= addr_nxt;
            avm_writedata <= data_nxt;
            avm_write     <= write_nxt;
            drained       <= drained_nxt;
            overflow      <= overflow_nxt;
            busy          <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ppu_write_collector.sv
// Scoreboard bench for ppu_write_collector: directed scenarios plus randomized traffic.
module tb_ppu_write_collector;
    import gpu_pkg::*;

    localparam int unsigned N      = 10;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned STRIDE = 96000;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [COLOR_WIDTH-1:0]   ppu_data    [N];
    logic [BUFFER_ADDR_W-1:0] ppu_address [N];
    logic [N-1:0]             ppu_valid = '0;
    logic [BUFFER_ADDR_W-1:0] fb_base = '0;
    logic                     frame_start = 1'b0;
    logic                     frame_end = 1'b0;
    logic [BUFFER_ADDR_W-1:0] avm_address;
    logic [COLOR_WIDTH-1:0]   avm_writedata;
    logic                     avm_write;
    logic                     avm_waitrequest = 1'b0;
    logic                     drained;
    logic [N-1:0]             overflow;
    logic                     busy;

    always #5 clk = ~clk;

    ppu_write_collector #(
        .CORES_COUNT (N),
        .FIFO_DEPTH  (DEPTH),
        .CORE_STRIDE (STRIDE)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ppu_data        (ppu_data),
        .ppu_address     (ppu_address),
        .ppu_valid       (ppu_valid),
        .fb_base         (fb_base),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .avm_address     (avm_address),
        .avm_writedata   (avm_writedata),
        .avm_write       (avm_write),
        .avm_waitrequest (avm_waitrequest),
        .drained         (drained),
        .overflow        (overflow),
        .busy            (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [47:0] exp_q [N][$];
    int comp_core [$];
    int comp_cyc  [$];
    int cyc = 0;
    int completions = 0;
    int drained_seen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[i].size();
        return s;
    endfunction

    task automatic step();
        @(negedge clk);
        ppu_valid   = '0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
    endtask

    // Drive one write for the coming edge; record=0 marks a write expected to be dropped.
    task automatic push(input int core, input logic [31:0] a, input logic [15:0] d, input bit record);
        ppu_valid[core]   = 1'b1;
        ppu_address[core] = a;
        ppu_data[core]    = d;
        if (record) exp_q[core].push_back({32'(fb_base + 32'(core) * STRIDE + a), d});
    endtask

    task automatic do_reset();
        step();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n = 0;
        while (outstanding() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        if (outstanding() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d writes still outstanding after %0d cycles", name, outstanding(), n);
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end
    endtask

    // Monitor: scores every completed transfer, bus hold stability and drained timing.
    initial begin : monitor
        bit          prev_stall = 0;
        logic [31:0] pa = '0;
        logic [15:0] pd = '0;
        bit          pend = 0;
        bit          pfe = 0;
        bit          pfs = 0;
        bit          exp_dr;
        logic [31:0] diff;
        int          core;
        logic [47:0] e;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                prev_stall = 0;
                pend = 0;
                pfe = 0;
                pfs = 0;
                continue;
            end
            if (pfe) pend = 1;
            else if (pfs) pend = 0;
            exp_dr = pend && ((outstanding() - $countones(ppu_valid)) == 0);
            chk("drained", 64'(drained), 64'(exp_dr));
            if (exp_dr) pend = 0;
            if (drained) drained_seen++;
            if (prev_stall) begin
                chk("hold_write", 64'(avm_write), 64'(1));
                chk("hold_bus", {avm_address, avm_writedata}, {pa, pd});
            end
            if (avm_write && !avm_waitrequest) begin
                diff = avm_address - fb_base;
                core = int'(diff / STRIDE);
                completions++;
                comp_core.push_back(core);
                comp_cyc.push_back(cyc);
                if (core >= N || exp_q[core].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h not expected", avm_address, avm_writedata);
                end else begin
                    e = exp_q[core].pop_front();
                    chk("write", 64'({avm_address, avm_writedata}), 64'(e));
                end
            end
            prev_stall = avm_write && avm_waitrequest;
            pa  = avm_address;
            pd  = avm_writedata;
            pfe = frame_end;
            pfs = frame_start;
        end
    end

    initial begin : driver
        int base;
        for (int i = 0; i < N; i++) begin
            ppu_data[i]    = '0;
            ppu_address[i] = '0;
        end

        // Reset state
        do_reset();
        #1;
        chk("rst_write", 64'(avm_write), 64'(0));
        chk("rst_drained", 64'(drained), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));

        // Single write, two-edge latency
        fb_base = 32'h1000;
        step();
        push(3, 32'h10, 16'hABCD, 1);
        step();
        #1;
        chk("lat_t1_write", 64'(avm_write), 64'(0));
        chk("lat_t1_busy", 64'(busy), 64'(1));
        step();
        #1;
        chk("lat_t2_write", 64'(avm_write), 64'(1));
        chk("single_addr", 64'(avm_address), 64'(32'h47510));
        chk("single_data", 64'(avm_writedata), 64'(16'hABCD));
        wait_drain("single", 50);

        // All cores at once: order 0..9 back to back
        do_reset();
        comp_core.delete();
        comp_cyc.delete();
        step();
        for (int i = 0; i < N; i++) push(i, 32'($urandom_range(0, STRIDE - 1)), 16'($urandom), 1);
        wait_drain("all_cores", 100);
        #1;
        chk("all_busy_after", 64'(busy), 64'(0));
        chk("all_count", 64'(comp_core.size()), 64'(N));
        if (comp_core.size() == N) begin
            for (int i = 0; i < N; i++) chk("all_order", 64'(comp_core[i]), 64'(i));
            chk("all_back_to_back", 64'(comp_cyc[N-1] - comp_cyc[0]), 64'(N - 1));
        end

        // Backpressure mid-burst
        base = completions;
        for (int r = 0; r < 2; r++) begin
            step();
            for (int i = 0; i < 5; i++) push(i, 32'($urandom_range(0, STRIDE - 1)), 16'($urandom), 1);
        end
        step();
        step();
        avm_waitrequest = 1'b1;
        repeat (5) step();
        avm_waitrequest = 1'b0;
        wait_drain("backpressure", 100);
        chk("bp_count", 64'(completions - base), 64'(10));

        // Overflow: 12 pushes into one stalled core, 9 survive
        do_reset();
        base = completions;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            push(0, 32'(i * 4), 16'(16'h100 + i), i < 9);
        end
        step();
        step();
        #1;
        chk("ovf_flag", 64'(overflow), 64'(1));
        avm_waitrequest = 1'b0;
        wait_drain("overflow", 100);
        repeat (3) step();
        chk("ovf_count", 64'(completions - base), 64'(9));
        chk("ovf_sticky", 64'(overflow), 64'(1));

        // Drain: frame_end with queued data, then release
        step();
        frame_start = 1'b1;
        step();
        #1;
        chk("fs_clears_ovf", 64'(overflow), 64'(0));
        drained_seen = 0;
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            push(2, 32'($urandom_range(0, STRIDE - 1)), 16'($urandom), 1);
        end
        step();
        frame_end = 1'b1;
        step();
        step();
        avm_waitrequest = 1'b0;
        wait_drain("drain", 100);
        repeat (4) step();
        chk("drain_pulses", 64'(drained_seen), 64'(1));

        // Reset while a write is stalled
        avm_waitrequest = 1'b1;
        step();
        push(5, 32'h40, 16'h5555, 0);
        step();
        step();
        #1;
        chk("pre_rst_write", 64'(avm_write), 64'(1));
        step();
        reset_n = 1'b0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        step();
        #1;
        chk("mid_rst_write", 64'(avm_write), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        step();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        base = completions;
        step();
        push(7, 32'h80, 16'h7777, 1);
        wait_drain("post_reset", 50);
        chk("post_rst_count", 64'(completions - base), 64'(1));

        // Randomized traffic with a wrapping base address
        fb_base = 32'hFFFF_8000;
        drained_seen = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 24) == 0)
                    push(i, 32'($urandom_range(0, STRIDE - 1)), 16'($urandom), 1);
            if (c == 599) frame_end = 1'b1;
        end
        step();
        avm_waitrequest = 1'b0;
        wait_drain("random", 300);
        repeat (4) step();
        chk("rand_overflow", 64'(overflow), 64'(0));
        chk("rand_drained", 64'(drained_seen), 64'(1));
        chk("rand_idle_busy", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
